// File: rtl/ref_pulse_pkg.sv
// Shared definitions for the reference pulse generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the FSM state encoding, the default field widths and the
// configuration values the generator wakes up with after reset.

package ref_pulse_pkg;

    // Generator states: waiting for start, driving the high phase,
    // driving the low phase.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // Default widths of the phase-length and pulse-count fields.
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_BURST_W = 16;

    // Configuration held after reset: one 2-cycle period, single pulse.
    localparam int RST_CFG_HIGH  = 1;
    localparam int RST_CFG_LOW   = 1;
    localparam int RST_CFG_COUNT = 1;

endpackage

// File: rtl/ref_pulse_gen_phase_timer.sv
// Loadable down-counter that times one high or low phase.
// Latency: expire asserts on the last cycle of a phase of load_val cycles.
// Backpressure: none; load always wins over counting.
//
// Ports:
//   fpga_clk1, reset_n : clock, async active-low reset
//   load               : start a new phase this cycle edge
//   load_val           : phase length in cycles (caller guarantees >= 1)
//   expire             : high while the current cycle is the phase's last

module phase_timer
    import ref_pulse_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             fpga_clk1,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    // cnt holds the number of cycles remaining after the current one,
    // so a phase of length P is loaded as P-1 and ends when cnt hits 0.
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge fpga_clk1 or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val - CNT_W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/ref_pulse_gen.sv
// Programmable reference pulse generator feeding the ring counter input.
// Latency: pulse_out rises the cycle after start; done one cycle after the last low phase.
// Backpressure: cfg_ready low while a burst runs; an offered config is held, not dropped.
//
// Ports:
//   fpga_clk1, reset_n          : clock, async active-low reset
//   cfg_valid/cfg_ready         : config handshake (accepted only in IDLE)
//   cfg_high, cfg_low           : phase lengths in cycles (0 behaves as 1)
//   cfg_count                   : pulses per burst (0 = run until stop)
//   start                       : begin a burst (ignored while busy)
//   stop                        : finish after the current period
//   pulse_out                   : generated square wave (registered)
//   busy                        : burst in progress
//   done                        : one-cycle strobe at burst end
//   pulses_sent                 : completed high phases since last start

module ref_pulse_gen
    import ref_pulse_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic               fpga_clk1,
    input  logic               reset_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_high,
    input  logic [CNT_W-1:0]   cfg_low,
    input  logic [BURST_W-1:0] cfg_count,
    input  logic               start,
    input  logic               stop,
    output logic               pulse_out,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] pulses_sent
);

    // Zero-length phases would produce no pulse at all; stretch to one cycle.
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    state_t             state;
    logic [CNT_W-1:0]   high_q;     // latched high length, already >= 1
    logic [CNT_W-1:0]   low_q;      // latched low length, already >= 1
    logic [BURST_W-1:0] count_q;    // latched burst length, 0 = continuous
    logic               stop_pend;  // stop seen during this burst

    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_val;
    logic               tmr_expire;
    logic               cfg_take;
    logic [CNT_W-1:0]   eff_high;
    logic               burst_end;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .fpga_clk1 (fpga_clk1),
        .reset_n   (reset_n),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .expire    (tmr_expire)
    );

    always_comb begin
        // A config offered alongside start must govern that very burst,
        // so the first high phase is timed from the incoming value.
        cfg_take = (state == IDLE) && cfg_valid;
        eff_high = cfg_take ? at_least_one(cfg_high) : high_q;

        // pulses_sent already includes the high phase of this period
        // while in LOW. A stop arriving on the final low cycle still
        // counts, since the period is complete at that point anyway.
        burst_end = ((count_q != '0) && (pulses_sent == count_q))
                    || stop_pend || stop;

        tmr_load = 1'b0;
        tmr_val  = high_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    tmr_load = 1'b1;
                    tmr_val  = eff_high;
                end
            end
            HIGH: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    tmr_val  = low_q;
                end
            end
            LOW: begin
                if (tmr_expire && !burst_end) begin
                    tmr_load = 1'b1;
                    tmr_val  = high_q;
                end
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge fpga_clk1 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pulse_out   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_ready   <= 1'b1;
            pulses_sent <= '0;
            stop_pend   <= 1'b0;
            high_q      <= CNT_W'(RST_CFG_HIGH);
            low_q       <= CNT_W'(RST_CFG_LOW);
            count_q     <= BURST_W'(RST_CFG_COUNT);
        end else begin
            done <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (cfg_take) begin
                        high_q  <= at_least_one(cfg_high);
                        low_q   <= at_least_one(cfg_low);
                        count_q <= cfg_count;
                    end
                    // stop is deliberately ignored here, including when
                    // it coincides with start.
                    if (start) begin
                        state       <= HIGH;
                        pulse_out   <= 1'b1;
                        busy        <= 1'b1;
                        cfg_ready   <= 1'b0;
                        pulses_sent <= '0;
                        stop_pend   <= 1'b0;
                    end
                end

                HIGH: begin
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    // A high phase is only ever ended by its timer, so
                    // stop can never shorten a pulse.
                    if (tmr_expire) begin
                        state       <= LOW;
                        pulse_out   <= 1'b0;
                        pulses_sent <= pulses_sent + BURST_W'(1);
                    end
                end

                LOW: begin
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (tmr_expire) begin
                        if (burst_end) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cfg_ready <= 1'b1;
                            stop_pend <= 1'b0;
                        end else begin
                            state     <= HIGH;
                            pulse_out <= 1'b1;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    pulse_out <= 1'b0;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/ref_pulse_gen.md
# ref_pulse_gen

Programmable reference pulse generator: the transmitting end of the ring-oscillator measurement path. It drives a square wave of known high/low duration, in cycles of `fpga_clk1`, into the `Ring_in` input of the counting circuit, in place of the ring oscillator output. This lets the counter and the seven-segment readout be calibrated against an exact expected value. It sits beside the ring oscillator in the top level, and a mux selects which source feeds the counter.

## Interface
Parameters:
- `CNT_W`, 16, width of the high/low phase length fields.
- `BURST_W`, 16, width of the pulse-count field and of the `pulses_sent` status counter.

Ports:
- `fpga_clk1`  in  1  sole clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  configuration offer; accepted when `cfg_valid && cfg_ready`.
- `cfg_ready`  out  1  high only in IDLE.
- `cfg_high`  in  CNT_W  high-phase length in cycles; 0 is treated as 1.
- `cfg_low`  in  CNT_W  low-phase length in cycles; 0 is treated as 1.
- `cfg_count`  in  BURST_W  number of pulses per burst; 0 means continuous.
- `start`  in  1  single-cycle request to begin a burst; ignored unless IDLE.
- `stop`  in  1  single-cycle request to end after the current period.
- `pulse_out`  out  1  generated waveform; registered, glitch-free.
- `busy`  out  1  high in HIGH or LOW state.
- `done`  out  1  one-cycle strobe when a burst ends (count reached or stop).
- `pulses_sent`  out  BURST_W  completed high phases since the last start; wraps modulo 2^BURST_W.

## Operation
- Reset values:
  - state IDLE; `pulse_out`=0, `busy`=0, `done`=0, `cfg_ready`=1, `pulses_sent`=0.
  - Latched configuration: high=1, low=1, count=1.
- States:
  - IDLE → HIGH on `start`.
  - HIGH → LOW when the high timer expires.
  - LOW → HIGH when the low timer expires and the burst is not finished.
  - LOW → IDLE when the low timer expires and the burst is finished (`pulses_sent`==count with count≠0, or stop pending).
- Config capture:
  - Occurs in IDLE only.
  - When `cfg_valid` and `start` are high in the same cycle, the burst uses the newly captured values.
  - Config offered while busy stays pending; `cfg_ready`=0, the offer is not consumed and the source must hold it.
- `pulses_sent`:
  - Cleared on an accepted `start`.
  - Incremented on each HIGH→LOW transition.
- `stop`:
  - Sets a sticky stop-pending flag while busy.
  - Never truncates a phase, so no runt pulse is produced; the burst ends at the end of the current LOW phase.
  - `stop` in IDLE has no effect. `stop` and `start` together in IDLE: start wins, stop is ignored.
- Continuous mode (count=0) runs until `stop`; `pulses_sent` wraps.
- `reset_n` asserted mid-burst forces `pulse_out` low and all state to reset values immediately (asynchronous).

## Timing
- `start` sampled high in cycle N:
  - `pulse_out`=1 and `busy`=1 from cycle N+1.
  - `pulse_out` stays high for exactly H=max(cfg_high,1) cycles, then low for exactly L=max(cfg_low,1) cycles.
  - Period = H+L cycles. Minimum is a 2-cycle period with 50% duty.
- A burst of C pulses occupies cycles N+1 … N+C·(H+L).
- `done`=1 and `busy`=0 in cycle N+C·(H+L)+1. `cfg_ready` returns to 1 in the same cycle.
- A new `start` may be accepted in the same cycle `done` is high.
- `pulses_sent` updates the cycle after the HIGH→LOW transition. It is valid together with `done`.
- Expected counter reading over a gate window of G cycles = floor(G/(H+L)) ±1.

## Structure
- Shared package `ref_pulse_pkg`:
  - state enum (IDLE, HIGH, LOW);
  - default `CNT_W`/`BURST_W` localparams;
  - reset-default config constants.
- One sub-module, `phase_timer`:
  - loadable CNT_W down-counter;
  - inputs: `load`, `load_val`;
  - output: `expire`, asserted on the last cycle of the phase;
  - instantiated once and reloaded with H or L at each phase change.
- Top of the block holds the FSM, the config registers, the stop-pending flag and the `pulses_sent` counter.

## Test plan
- Reset then start (default cfg) → `pulse_out` 1,0 for one 2-cycle period; `done` at start+3; `pulses_sent`=1.
- cfg high=3, low=5, count=4, start at cycle 10 → `pulse_out` high at cycles 11–13, 19–21, 27–29, 35–37; `done` at cycle 43; `pulses_sent`=4.
- cfg high=0, low=0, count=2 → identical to high=1, low=1: pulses at start+1 and start+3.
- Continuous mode high=2, low=2, stop asserted in the 2nd cycle of the 3rd HIGH phase → that period completes; `done` 12 cycles after start+1… i.e. at start+13; `pulses_sent`=3.
- `cfg_valid` held during a burst → `cfg_ready`=0 throughout; the new values are captured in the `done` cycle and used by the next start. `start` during busy → ignored and `pulses_sent` is not cleared.
- `reset_n` low mid-HIGH (asynchronous, between clock edges) → `pulse_out`=0 before the next clock edge; `cfg_ready`=1; defaults restored.
